// File: rtl/sigma_memory_responder.sv
// Word-addressed RAM responder for a big-endian CPU with a loader port and a
// memory-mapped console byte FIFO; out-of-range writes and FIFO overflow are sticky.
module sigma_memory_responder #(
    parameter int unsigned DEPTH_WORDS  = 4096,
    parameter logic [16:0] CONSOLE_ADDR = 17'h1FFFF,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [15:31] memory_address,
    input  logic [0:31]  cpu_wdata,
    input  logic [0:3]   wr_enables,
    output logic [0:31]  cpu_rdata,
    input  logic         load_we,
    input  logic [15:31] load_addr,
    input  logic [0:31]  load_data,
    output logic [7:0]   console_data,
    output logic         console_valid,
    input  logic         console_ready,
    output logic         range_err,
    output logic         console_ovf
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    logic [16:0]   addr_c, laddr_c;
    logic [AW-1:0] cidx_c, lidx_c;
    logic          is_console_c, in_range_c, out_range_c, any_we_c;

    // Address decode; the console address wins over RAM when it falls inside it.
    assign addr_c       = memory_address;
    assign laddr_c      = load_addr;
    assign cidx_c       = addr_c[AW-1:0];
    assign lidx_c       = laddr_c[AW-1:0];
    assign any_we_c     = |wr_enables;
    assign is_console_c = (addr_c == CONSOLE_ADDR);
    assign in_range_c   = !is_console_c && (32'(addr_c) < DEPTH_WORDS);
    assign out_range_c  = !is_console_c && !in_range_c;

    logic [0:31] mem_q [DEPTH_WORDS];

    // RAM has no reset; the loader has priority over the CPU byte-lane write.
    always_ff @(posedge clock) begin
        if (load_we) begin
            mem_q[lidx_c] <= load_data;
        end else if (in_range_c && any_we_c) begin
            for (int l = 0; l < 4; l++) begin
                if (wr_enables[l]) mem_q[cidx_c][8*l +: 8] <= cpu_wdata[8*l +: 8];
            end
        end
    end

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_c, empty_c, push_c, pop_c, accept_c;
    logic [7:0]    push_byte_c;

    assign full_c   = (count_q == CW'(FIFO_DEPTH));
    assign empty_c  = (count_q == '0);
    assign push_c   = is_console_c && any_we_c;
    assign pop_c    = !empty_c && console_ready;
    assign accept_c = push_c && (!full_c || pop_c);

    // The highest-numbered enabled lane supplies the pushed byte.
    always_comb begin
        push_byte_c = cpu_wdata[0:7];
        for (int l = 0; l < 4; l++) begin
            if (wr_enables[l]) push_byte_c = cpu_wdata[8*l +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (accept_c) fifo_q[wr_ptr_q] <= push_byte_c;
    end

    always_comb begin
        rd_ptr_d = pop_c ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = accept_c ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(accept_c) - CW'(pop_c);
    end

    logic [0:31] status_c, rdata_d, rdata_q;
    logic        rerr_d, rerr_q, ovf_d, ovf_q;

    always_comb begin
        status_c        = '0;
        status_c[24:27] = 4'(count_q);
        status_c[30]    = full_c;
        status_c[31]    = empty_c;
        if (is_console_c)    rdata_d = status_c;
        else if (in_range_c) rdata_d = mem_q[cidx_c];
        else                 rdata_d = '0;
        rerr_d = rerr_q || (out_range_c && any_we_c);
        ovf_d  = ovf_q || (push_c && full_c && !pop_c);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rdata_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            rerr_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rerr_q   <= rerr_d;
            ovf_q    <= ovf_d;
        end
    end

    assign cpu_rdata     = rdata_q;
    assign range_err     = rerr_q;
    assign console_ovf   = ovf_q;
    assign console_valid = !empty_c;
    assign console_data  = fifo_q[rd_ptr_q];
endmodule

// File: tb/tb_sigma_memory_responder.sv
// Bench for sigma_memory_responder: directed scenarios then random traffic,
// checked against an array/queue model of the memory map.
module tb_sigma_memory_responder;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned CON   = 32'h1FFFF;
    localparam int unsigned FD    = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [15:31] memory_address;
    logic [0:31]  cpu_wdata;
    logic [0:3]   wr_enables;
    logic [0:31]  cpu_rdata;
    logic         load_we;
    logic [15:31] load_addr;
    logic [0:31]  load_data;
    logic [7:0]   console_data;
    logic         console_valid;
    logic         console_ready;
    logic         range_err;
    logic         console_ovf;

    sigma_memory_responder dut (
        .clock(clock), .reset(reset),
        .memory_address(memory_address), .cpu_wdata(cpu_wdata), .wr_enables(wr_enables),
        .cpu_rdata(cpu_rdata),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
        .console_data(console_data), .console_valid(console_valid), .console_ready(console_ready),
        .range_err(range_err), .console_ovf(console_ovf)
    );

    always #5 clock = ~clock;

    logic [31:0] ram [DEPTH];
    logic [7:0]  q [$];
    bit          m_rerr, m_ovf;
    int          total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: predict from the pre-edge inputs, advance the model, compare after the edge.
    task automatic cycle(input string tag);
        logic [31:0] a, wd, e_rd;
        logic [3:0]  we;
        logic [7:0]  pb;
        int          sz;
        bit          push, pop;
        a  = 32'(memory_address);
        wd = cpu_wdata;
        we = wr_enables;
        sz = q.size();
        if (a == CON)        e_rd = {24'h0, 4'(sz), 2'b00, sz == FD, sz == 0};
        else if (a < DEPTH)  e_rd = ram[a];
        else                 e_rd = 32'h0;
        pop  = (sz != 0) && console_ready;
        push = (a == CON) && (we != 0);
        pb   = 8'h0;
        for (int l = 0; l < 4; l++) if (we[3-l]) pb = wd[31-8*l -: 8];
        if (pop) void'(q.pop_front());
        if (push) begin
            if (sz < FD || pop) q.push_back(pb);
            else m_ovf = 1'b1;
        end
        if (we != 0 && a >= DEPTH && a != CON) m_rerr = 1'b1;
        if (load_we) ram[32'(load_addr) % DEPTH] = load_data;
        else if (we != 0 && a < DEPTH && a != CON)
            for (int l = 0; l < 4; l++) if (we[3-l]) ram[a][31-8*l -: 8] = wd[31-8*l -: 8];
        @(posedge clock);
        #1;
        chk({tag, ".rdata"}, cpu_rdata, e_rd);
        chk({tag, ".valid"}, 32'(console_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk({tag, ".data"}, 32'(console_data), 32'(q[0]));
        chk({tag, ".rerr"}, 32'(range_err), 32'(m_rerr));
        chk({tag, ".ovf"}, 32'(console_ovf), 32'(m_ovf));
    endtask

    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] we, input logic rdy);
        memory_address = 17'(a);
        cpu_wdata      = wd;
        wr_enables     = we;
        console_ready  = rdy;
        load_we        = 1'b0;
        cycle(tag);
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        memory_address = 17'h0;
        wr_enables     = 4'h0;
        console_ready  = 1'b0;
        load_we        = 1'b1;
        load_addr      = 17'(a);
        load_data      = d;
        cycle("load");
        load_we        = 1'b0;
    endtask

    // Asynchronous reset applied between edges; checked before any clock edge.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        q.delete();
        m_rerr = 1'b0;
        m_ovf  = 1'b0;
        #1;
        chk({tag, ".rst_rdata"}, cpu_rdata, 32'h0);
        chk({tag, ".rst_valid"}, 32'(console_valid), 32'h0);
        chk({tag, ".rst_rerr"}, 32'(range_err), 32'h0);
        chk({tag, ".rst_ovf"}, 32'(console_ovf), 32'h0);
        memory_address = 17'h0;
        wr_enables     = 4'h0;
        load_we        = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        logic [7:0]  last;
        int          r;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        memory_address = 17'h0;
        cpu_wdata      = 32'h0;
        wr_enables     = 4'h0;
        console_ready  = 1'b0;
        load_we        = 1'b0;
        load_addr      = 17'h0;
        load_data      = 32'h0;
        #2;
        reset = 1'b1;
        #1;
        chk("reset.rdata", cpu_rdata, 32'h0);
        chk("reset.valid", 32'(console_valid), 32'h0);
        chk("reset.rerr", 32'(range_err), 32'h0);
        chk("reset.ovf", 32'(console_ovf), 32'h0);
        // Initialise every RAM word through the loader while reset is held.
        load_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            load_addr = 17'(i);
            load_data = $urandom;
            ram[i]    = load_data;
            @(posedge clock);
            #1;
        end
        load_we = 1'b0;
        chk("reset.hold_rdata", cpu_rdata, 32'h0);
        reset = 1'b0;

        // Loader write then one-edge read latency
        load(32'h40, 32'h22100005);
        step("ld_read", 32'h40, 32'h0, 4'h0, 1'b0);
        chk("ld_read.const", cpu_rdata, 32'h22100005);

        // Single byte-lane write
        load(32'h40, 32'h11223344);
        step("lane_wr", 32'h40, 32'hAABBCCDD, 4'b0100, 1'b0);
        step("lane_rd", 32'h40, 32'h0, 4'h0, 1'b0);
        chk("lane_rd.const", cpu_rdata, 32'h11BB3344);

        // Read-first on a same-edge write
        step("rf_wr", 32'h40, 32'hDEADBEEF, 4'b1111, 1'b0);
        chk("rf_wr.old", cpu_rdata, 32'h11BB3344);
        step("rf_rd", 32'h40, 32'h0, 4'h0, 1'b0);
        chk("rf_rd.new", cpu_rdata, 32'hDEADBEEF);

        // Nine pushes into an eight-entry FIFO with the sink stalled
        for (int i = 0; i < 9; i++) step("push9", CON, 32'h41 + 32'(i), 4'b0001, 1'b0);
        chk("push9.ovf", 32'(console_ovf), 32'h1);
        step("stat_full", CON, 32'h0, 4'h0, 1'b0);
        chk("stat_full.const", cpu_rdata, 32'h00000082);
        for (int i = 0; i < 8; i++) begin
            chk("drain9.order", 32'(console_data), 32'h41 + 32'(i));
            step("drain9", 32'h0, 32'h0, 4'h0, 1'b1);
        end
        chk("drain9.empty", 32'(console_valid), 32'h0);

        // Push into a full FIFO concurrent with a pop
        pulse_reset("r2");
        for (int i = 0; i < 8; i++) step("fill8", CON, 32'h41 + 32'(i), 4'b1111, 1'b0);
        step("push_pop", CON, 32'h0000005A, 4'b0001, 1'b1);
        chk("push_pop.ovf", 32'(console_ovf), 32'h0);
        step("stat_pp", CON, 32'h0, 4'h0, 1'b0);
        chk("stat_pp.count", cpu_rdata, 32'h00000082);
        last = 8'h0;
        for (int i = 0; i < 8; i++) begin
            last = console_data;
            step("drain_pp", 32'h0, 32'h0, 4'h0, 1'b1);
        end
        chk("drain_pp.last", 32'(last), 32'h5A);
        chk("drain_pp.empty", 32'(console_valid), 32'h0);

        // Lane-0-only push selects the top byte
        step("lane0_push", CON, 32'hC3000000, 4'b1000, 1'b0);
        chk("lane0_push.byte", 32'(console_data), 32'hC3);

        // Out-of-range write, read, then reset mid-drain
        step("oor_wr", 32'h01000, 32'hFFFFFFFF, 4'b1111, 1'b0);
        chk("oor_wr.rerr", 32'(range_err), 32'h1);
        step("oor_rd", 32'h01000, 32'h0, 4'h0, 1'b0);
        chk("oor_rd.zero", cpu_rdata, 32'h0);
        step("ram0_rd", 32'h0, 32'h0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) step("push3", CON, 32'h60 + 32'(i), 4'b0001, 1'b0);
        step("drain_mid", 32'h0, 32'h0, 4'h0, 1'b1);
        pulse_reset("r3");
        step("post_rst", 32'h40, 32'h0, 4'h0, 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6)      a = $urandom_range(0, 63);
            else if (r < 8) a = CON;
            else            a = $urandom_range(DEPTH, 32'h1FFFE);
            memory_address = 17'(a);
            cpu_wdata      = $urandom;
            wr_enables     = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            console_ready  = ($urandom_range(0, 2) == 0);
            load_we        = ($urandom_range(0, 7) == 0);
            load_addr      = 17'($urandom_range(0, 63));
            d              = $urandom;
            load_data      = d;
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
